// File: rtl/rtlupbus_initiator.sv
// Host-side master for the upen/upa/upws/uprs/uprdy RAM-CPU bus: turns one valid/ready
// request into one strobed bus access, with timeout abort and a saturating error count.
module rtlupbus_initiator #(
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32,
  parameter int TOUT    = 255,
  parameter int TOUTBIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic               req_wr,
  input  logic [ADDRBIT-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_wdat,
  output logic               rsp_vld,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   rsp_rdat,
  output logic [TOUTBIT-1:0] tout_cnt,
  output logic               upen,
  output logic [ADDRBIT-1:0] upa,
  output logic               upws,
  output logic               uprs,
  output logic [WIDTH-1:0]   updi,
  input  logic [WIDTH-1:0]   updo,
  input  logic               uprdy
);

  // state  | meaning
  // S_IDLE | req_rdy high, bus idle, waiting for a host request
  // S_STRB | one-cycle write/read strobe with upen high
  // S_WAIT | upen held, counting cycles until uprdy or timeout
  // S_GAP  | upen low for one cycle, rsp_vld pulse
  typedef enum logic [1:0] {S_IDLE, S_STRB, S_WAIT, S_GAP} state_t;

  localparam logic [TOUTBIT-1:0] TOUT_C = TOUTBIT'(TOUT);

  state_t               state_q;
  logic                 wr_q;
  logic [TOUTBIT-1:0]   cnt_q;
  logic [TOUTBIT-1:0]   cnt_d;
  logic                 req_rdy_q;
  logic                 rsp_vld_q;
  logic                 rsp_err_q;
  logic [WIDTH-1:0]     rsp_rdat_q;
  logic [TOUTBIT-1:0]   tout_cnt_q;
  logic                 upen_q;
  logic [ADDRBIT-1:0]   upa_q;
  logic                 upws_q;
  logic                 uprs_q;
  logic [WIDTH-1:0]     updi_q;

  // Compare against the incremented value so exactly TOUT WAIT cycles are allowed.
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      req_rdy_q  <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_rdat_q <= '0;
      tout_cnt_q <= '0;
      upen_q     <= 1'b0;
      upa_q      <= '0;
      upws_q     <= 1'b0;
      uprs_q     <= 1'b0;
      updi_q     <= '0;
    end else begin
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      upws_q    <= 1'b0;
      uprs_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_vld) begin
            state_q   <= S_STRB;
            req_rdy_q <= 1'b0;
            wr_q      <= req_wr;
            upen_q    <= 1'b1;
            upa_q     <= req_addr;
            updi_q    <= req_wdat;
            upws_q    <= req_wr;
            uprs_q    <= ~req_wr;
            cnt_q     <= '0;
          end
        end
        S_STRB: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (uprdy) begin
            state_q    <= S_GAP;
            upen_q     <= 1'b0;
            upa_q      <= '0;
            updi_q     <= '0;
            rsp_vld_q  <= 1'b1;
            rsp_rdat_q <= wr_q ? '0 : updo;
          end else if (cnt_d == TOUT_C) begin
            // Dropping upen here is what aborts the responder's pending access.
            state_q    <= S_GAP;
            upen_q     <= 1'b0;
            upa_q      <= '0;
            updi_q     <= '0;
            rsp_vld_q  <= 1'b1;
            rsp_err_q  <= 1'b1;
            rsp_rdat_q <= '0;
            if (tout_cnt_q != '1) tout_cnt_q <= tout_cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q    <= S_IDLE;
          req_rdy_q  <= 1'b1;
          rsp_rdat_q <= '0;
        end
        default: begin
          state_q   <= S_IDLE;
          req_rdy_q <= 1'b1;
          upen_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy  = req_rdy_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_err  = rsp_err_q;
  assign rsp_rdat = rsp_rdat_q;
  assign tout_cnt = tout_cnt_q;
  assign upen     = upen_q;
  assign upa      = upa_q;
  assign upws     = upws_q;
  assign uprs     = uprs_q;
  assign updi     = updi_q;

endmodule

// File: tb/tb_rtlupbus_initiator.sv
// Directed bench for rtlupbus_initiator (TOUT=8): a scripted responder drives uprdy/updo
// and each access is checked against hand-derived cycle timing and data.
module tb_rtlupbus_initiator;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [4:0]  req_addr;
  logic [31:0] req_wdat;
  logic        rsp_vld;
  logic        rsp_err;
  logic [31:0] rsp_rdat;
  logic [7:0]  tout_cnt;
  logic        upen;
  logic [4:0]  upa;
  logic        upws;
  logic        uprs;
  logic [31:0] updi;
  logic [31:0] updo;
  logic        uprdy;

  int checks = 0;
  int errors = 0;

  rtlupbus_initiator #(.ADDRBIT(5), .WIDTH(32), .TOUT(8), .TOUTBIT(8)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdat(req_wdat),
    .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_rdat(rsp_rdat), .tout_cnt(tout_cnt),
    .upen(upen), .upa(upa), .upws(upws), .uprs(uprs), .updi(updi),
    .updo(updo), .uprdy(uprdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // t=1 is the cycle right after the accepting edge (STRB); uprdy is held during cycle rdy_t.
  task automatic run_access(input logic wr, input logic [4:0] a, input logic [31:0] d,
                            input int rdy_t, input logic [31:0] rdata,
                            output int rsp_t, output logic err, output logic [31:0] rdat,
                            output int upen_hi, output int ws_n, output int rs_n,
                            output logic bus_ok);
    rsp_t = -1; err = 1'b0; rdat = '0; upen_hi = 0; ws_n = 0; rs_n = 0; bus_ok = 1'b1;
    for (int k = 0; k < 20 && !req_rdy; k++) tick();
    if (!req_rdy) chk("rdy_wait", 32'(req_rdy), 32'd1);
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdat = d;
    tick();
    req_vld = 1'b0; req_wr = ~wr; req_addr = ~a; req_wdat = ~d;
    for (int t = 1; t <= 40; t++) begin
      if (rsp_vld) begin
        rsp_t = t; err = rsp_err; rdat = rsp_rdat;
        if (upen || upa != 5'd0 || updi != 32'd0 || upws || uprs) bus_ok = 1'b0;
        break;
      end
      if (upen) begin
        upen_hi++;
        if (upa !== a || updi !== d) bus_ok = 1'b0;
      end else begin
        bus_ok = 1'b0;
      end
      ws_n += int'(upws);
      rs_n += int'(uprs);
      uprdy = (t == rdy_t);
      updo  = (t == rdy_t) ? rdata : 32'hBAD0_BAD0;
      tick();
    end
    uprdy = 1'b0;
    updo  = 32'hBAD0_BAD0;
    if (rsp_t < 0) chk("rsp_wait", 32'(rsp_vld), 32'd1);
  endtask

  int          rt, uh, ws, rs;
  logic        er, bok, all_err, quiet;
  logic [31:0] rd;

  initial begin
    rst = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdat = '0;
    updo = '0; uprdy = 1'b0;
    repeat (3) tick();
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_upen", 32'(upen), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_tout", 32'(tout_cnt), 32'd0);
    chk("rst_bus", {upa, upws, uprs, rsp_err}, 32'd0);
    chk("rst_updi", updi, 32'd0);
    chk("rst_rdat", rsp_rdat, 32'd0);
    rst = 1'b1;
    tick();

    // 1: write, uprdy on the 4th WAIT cycle
    run_access(1'b1, 5'h05, 32'hDEAD_BEEF, 5, 32'h1111_1111, rt, er, rd, uh, ws, rs, bok);
    chk("t1_rsp_t", 32'(rt), 32'd6);
    chk("t1_err", 32'(er), 32'd0);
    chk("t1_rdat", rd, 32'd0);
    chk("t1_upen_hi", 32'(uh), 32'd5);
    chk("t1_upws", 32'(ws), 32'd1);
    chk("t1_uprs", 32'(rs), 32'd0);
    chk("t1_bus", 32'(bok), 32'd1);
    tick();
    chk("t1_req_rdy", 32'(req_rdy), 32'd1);
    chk("t1_vld_pulse", 32'(rsp_vld), 32'd0);

    // 2: read A=0x1F
    run_access(1'b0, 5'h1F, 32'h0000_0000, 5, 32'h1234_5678, rt, er, rd, uh, ws, rs, bok);
    chk("t2_rsp_t", 32'(rt), 32'd6);
    chk("t2_rdat", rd, 32'h1234_5678);
    chk("t2_uprs", 32'(rs), 32'd1);
    chk("t2_upws", 32'(ws), 32'd0);
    chk("t2_bus", 32'(bok), 32'd1);

    // 3: timeout after 8 WAIT cycles, then a late uprdy is ignored
    run_access(1'b0, 5'h0A, 32'h0, 0, 32'h0, rt, er, rd, uh, ws, rs, bok);
    chk("t3_rsp_t", 32'(rt), 32'd10);
    chk("t3_err", 32'(er), 32'd1);
    chk("t3_rdat", rd, 32'd0);
    chk("t3_upen_hi", 32'(uh), 32'd9);
    chk("t3_tout", 32'(tout_cnt), 32'd1);
    tick(); tick();
    uprdy = 1'b1; updo = 32'hFFFF_FFFF;
    tick();
    uprdy = 1'b0;
    chk("t3_late_vld", 32'(rsp_vld), 32'd0);
    chk("t3_late_upen", 32'(upen), 32'd0);
    chk("t3_late_rdy", 32'(req_rdy), 32'd1);
    tick();
    chk("t3_late_vld2", 32'(rsp_vld), 32'd0);
    chk("t3_late_tout", 32'(tout_cnt), 32'd1);

    // 4: uprdy on the 8th WAIT cycle beats the timeout
    run_access(1'b0, 5'h11, 32'h0, 9, 32'hCAFE_F00D, rt, er, rd, uh, ws, rs, bok);
    chk("t4_rsp_t", 32'(rt), 32'd10);
    chk("t4_err", 32'(er), 32'd0);
    chk("t4_rdat", rd, 32'hCAFE_F00D);
    chk("t4_tout", 32'(tout_cnt), 32'd1);

    // 5: reset asserted during WAIT
    tick();
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 5'h03; req_wdat = 32'h0;
    tick();
    req_vld = 1'b0;
    tick(); tick();
    chk("t5_in_wait", 32'(upen), 32'd1);
    rst = 1'b0;
    tick();
    chk("t5_upen", 32'(upen), 32'd0);
    chk("t5_req_rdy", 32'(req_rdy), 32'd1);
    chk("t5_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("t5_tout", 32'(tout_cnt), 32'd0);
    rst = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_vld) quiet = 1'b0;
    end
    chk("t5_no_rsp", 32'(quiet), 32'd1);
    run_access(1'b0, 5'h07, 32'h0, 4, 32'h0BAD_F00D, rt, er, rd, uh, ws, rs, bok);
    chk("t5_rsp_t", 32'(rt), 32'd5);
    chk("t5_rdat", rd, 32'h0BAD_F00D);
    chk("t5_err", 32'(er), 32'd0);

    // 6: 300 forced timeouts saturate tout_cnt
    all_err = 1'b1;
    for (int i = 0; i < 300; i++) begin
      run_access(1'b0, 5'(i), 32'h0, 0, 32'h0, rt, er, rd, uh, ws, rs, bok);
      all_err &= er;
      if (i == 9) chk("t6_tout10", 32'(tout_cnt), 32'd10);
    end
    chk("t6_all_err", 32'(all_err), 32'd1);
    chk("t6_tout_sat", 32'(tout_cnt), 32'd255);

    // uprdy during STRB is outside WAIT and must not complete the access
    run_access(1'b0, 5'h02, 32'h0, 1, 32'h5555_5555, rt, er, rd, uh, ws, rs, bok);
    chk("strb_rdy_rsp_t", 32'(rt), 32'd10);
    chk("strb_rdy_err", 32'(er), 32'd1);
    chk("strb_rdy_tout", 32'(tout_cnt), 32'd255);

    // back-to-back reads, uprdy on the first WAIT cycle
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, 5'(i + 8), 32'h0, 2, 32'hA5A5_0000 + 32'(i), rt, er, rd, uh, ws, rs, bok);
      chk("b2b_rsp_t", 32'(rt), 32'd3);
      chk("b2b_rdat", rd, 32'hA5A5_0000 + 32'(i));
      chk("b2b_gap", 32'(bok), 32'd1);
      chk("b2b_upen_hi", 32'(uh), 32'd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
